// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_if
// Description : Handshake bundle for the ByteDecode unpacker (word in, pairs out).
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_if #(
    parameter int W_IN   = 64,
    parameter int W_COEF = 12
);
    logic                  i_start;
    logic [3:0]            i_l;
    logic [W_IN-1:0]       i_ibytes;
    logic                  i_ibytes_valid;
    logic                  o_ibytes_ready;
    logic [2*W_COEF-1:0]   o_coeffs;
    logic                  o_coeffs_valid;
    logic                  i_coeffs_ready;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_l, i_ibytes, i_ibytes_valid, i_coeffs_ready,
        output o_ibytes_ready, o_coeffs, o_coeffs_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_l, i_ibytes, i_ibytes_valid, i_coeffs_ready,
        input  o_ibytes_ready, o_coeffs, o_coeffs_valid, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
// Module      : decode
// Description : Kyber ByteDecode_l - unpacks 64-bit LE words into 256 coefs, two per beat.
// Revision    : 1.0 - initial release
// ============================================================================
module decode #(
    parameter int W_IN     = 64,
    parameter int W_COEF   = 12,
    parameter int N_COEFFS = 256,
    parameter int Q        = 3329
) (
    input  logic     i_clk,
    input  logic     i_rstn,
    decode_if.slave  bus
);

    localparam int c_BUF_W  = 2 * W_IN;
    localparam int c_CNT_W  = $clog2(c_BUF_W + 1);
    localparam int c_PAIR_W = $clog2(N_COEFFS / 2);
    localparam logic [W_COEF-1:0] c_Q = W_COEF'(Q);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [3:0]            r_l;
    logic [c_BUF_W-1:0]    r_buf;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [5:0]            r_word_cnt;
    logic [c_PAIR_W-1:0]   r_pair_cnt;
    logic [2*W_COEF-1:0]   r_coeffs;
    logic                  r_coeffs_valid;

    logic                  w_l_legal;
    logic                  w_start_ok;
    logic                  w_run;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_ibytes_ready;
    logic                  w_accept;
    logic                  w_extract;
    logic                  w_last_hs;
    logic [c_CNT_W-1:0]    w_step;
    logic [c_CNT_W-1:0]    w_cnt_after;
    logic [c_CNT_W-1:0]    w_bit_cnt_next;
    logic [c_BUF_W-1:0]    w_buf_shift;
    logic [c_BUF_W-1:0]    w_buf_next;
    logic [W_COEF-1:0]     w_mask;
    logic [W_COEF-1:0]     w_lane0_raw;
    logic [W_COEF-1:0]     w_lane1_raw;
    logic [W_COEF-1:0]     w_lane0;
    logic [W_COEF-1:0]     w_lane1;

    always_comb begin
        w_l_legal = 1'b0;
        case (bus.i_l)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: w_l_legal = 1'b1;
            default:                               w_l_legal = 1'b0;
        endcase
    end

    assign w_start_ok = bus.i_start && w_l_legal;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (w_start_ok) w_state_next = c_S_RUN;
            c_S_RUN:  if (w_last_hs)  w_state_next = c_S_DONE;
            c_S_DONE: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_run          = (r_state == c_S_RUN);
        w_busy         = (r_state != c_S_IDLE);
        w_done         = (r_state == c_S_DONE);
        w_ibytes_ready = w_run && (r_word_cnt < {r_l, 2'b00}) &&
                         (r_bit_cnt <= c_CNT_W'(W_IN));
    end

    assign w_step    = c_CNT_W'({r_l, 1'b0});
    assign w_accept  = w_ibytes_ready && bus.i_ibytes_valid;
    assign w_extract = w_run && (r_bit_cnt >= w_step) &&
                       (!r_coeffs_valid || bus.i_coeffs_ready);

    // All 4L words in and the pair counter wrapped: the pair on the bus is the last one.
    assign w_last_hs = w_run && r_coeffs_valid && bus.i_coeffs_ready &&
                       (r_word_cnt == {r_l, 2'b00}) && (r_pair_cnt == '0);

    // Extract consumes from the bottom first; a same-cycle word lands above what remains.
    assign w_cnt_after    = w_extract ? (r_bit_cnt - w_step) : r_bit_cnt;
    assign w_buf_shift    = w_extract ? (r_buf >> w_step) : r_buf;
    assign w_buf_next     = w_accept
                          ? (w_buf_shift | ({{W_IN{1'b0}}, bus.i_ibytes} << w_cnt_after))
                          : w_buf_shift;
    assign w_bit_cnt_next = w_cnt_after + (w_accept ? c_CNT_W'(W_IN) : '0);

    assign w_mask      = W_COEF'(((W_COEF+1)'(1) << r_l) - (W_COEF+1)'(1));
    assign w_lane0_raw = r_buf[W_COEF-1:0] & w_mask;
    assign w_lane1_raw = W_COEF'(r_buf[2*W_COEF-1:0] >> r_l) & w_mask;

    // Single conditional subtract suffices: a 12-bit value is below 2Q.
    assign w_lane0 = ((r_l == 4'd12) && (w_lane0_raw >= c_Q)) ? (w_lane0_raw - c_Q) : w_lane0_raw;
    assign w_lane1 = ((r_l == 4'd12) && (w_lane1_raw >= c_Q)) ? (w_lane1_raw - c_Q) : w_lane1_raw;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_l            <= '0;
            r_buf          <= '0;
            r_bit_cnt      <= '0;
            r_word_cnt     <= '0;
            r_pair_cnt     <= '0;
            r_coeffs       <= '0;
            r_coeffs_valid <= 1'b0;
        end else if ((r_state == c_S_IDLE) && w_start_ok) begin
            r_l            <= bus.i_l;
            r_buf          <= '0;
            r_bit_cnt      <= '0;
            r_word_cnt     <= '0;
            r_pair_cnt     <= '0;
            r_coeffs_valid <= 1'b0;
        end else begin
            if (w_accept || w_extract) begin
                r_buf     <= w_buf_next;
                r_bit_cnt <= w_bit_cnt_next;
            end
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_extract) begin
                r_coeffs       <= {w_lane1, w_lane0};
                r_pair_cnt     <= r_pair_cnt + 1'b1;
                r_coeffs_valid <= 1'b1;
            end else if (r_coeffs_valid && bus.i_coeffs_ready) begin
                r_coeffs_valid <= 1'b0;
            end
        end
    end

    assign bus.o_ibytes_ready = w_ibytes_ready;
    assign bus.o_coeffs       = r_coeffs;
    assign bus.o_coeffs_valid = r_coeffs_valid;
    assign bus.o_busy         = w_busy;
    assign bus.o_done         = w_done;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode
// Description : Self-checking bench for decode: start-vector table plus scoreboarded frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    decode_if bus ();

    decode dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [3:0] l;
        logic       exp_busy;
        logic       exp_rdy;
    } start_vec_t;

    int total = 0;
    int bad   = 0;

    logic [23:0] q[$];
    logic [63:0] words[48];
    logic [11:0] coefs[256];

    bit          mon_en = 1'b0;
    bit          in_run = 1'b0;
    bit          done_due = 1'b0;
    bit          prev_stall = 1'b0;
    bit          first_seen = 1'b0;
    logic [23:0] prev_coeffs = '0;
    logic [23:0] first_pair = '0;
    logic [3:0]  cur_l = 4'd1;
    int          acc_words = 0;
    int          hs_pairs = 0;
    int          done_cnt = 0;
    int          nwords = 0;
    int          m_bc;
    bit          m_rdy;
    logic [23:0] m_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] red(input logic [11:0] v, input logic [3:0] l);
        return ((l == 4'd12) && (v >= 12'd3329)) ? (v - 12'd3329) : v;
    endfunction

    // Encode reference: coef i occupies stream bits [i*l +: l], LSB first.
    task automatic pack(input logic [3:0] l);
        int n;
        for (int w = 0; w < 48; w++) words[w] = '0;
        for (int i = 0; i < 256; i++) begin
            for (int b = 0; b < int'(l); b++) begin
                n = i * int'(l) + b;
                words[n / 64][n % 64] = coefs[i][b];
            end
        end
    endtask

    task automatic rand_coefs(input logic [3:0] l);
        for (int i = 0; i < 256; i++) coefs[i] = 12'($urandom_range(0, (1 << int'(l)) - 1));
    endtask

    task automatic push_expected(input logic [3:0] l);
        for (int i = 0; i < 256; i += 2) q.push_back({red(coefs[i+1], l), red(coefs[i], l)});
    endtask

    // Monitor: samples on the falling edge what the next rising edge will commit.
    always @(negedge clk) begin
        if (mon_en) begin
            m_bc  = 64 * acc_words - 2 * int'(cur_l) * (hs_pairs + int'(bus.o_coeffs_valid));
            m_rdy = in_run && (acc_words < 4 * int'(cur_l)) && (m_bc <= 64);
            chk("ibytes_ready", 64'(bus.o_ibytes_ready), 64'(m_rdy));
            chk("busy", 64'(bus.o_busy), 64'(in_run || done_due));
            chk("done", 64'(bus.o_done), 64'(done_due));
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.o_coeffs_valid), 64'd1);
                chk("hold_data", 64'(bus.o_coeffs), 64'(prev_coeffs));
            end
            done_due = 1'b0;
            if (bus.o_done) done_cnt++;
            prev_stall  = bus.o_coeffs_valid && !bus.i_coeffs_ready;
            prev_coeffs = bus.o_coeffs;
            if (bus.o_coeffs_valid && bus.i_coeffs_ready) begin
                if (!first_seen) begin
                    first_pair = bus.o_coeffs;
                    first_seen = 1'b1;
                end
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pair_extra: got %0h expected none", bus.o_coeffs);
                end else begin
                    m_exp = q.pop_front();
                    chk("pair", 64'(bus.o_coeffs), 64'(m_exp));
                end
                hs_pairs++;
                if (hs_pairs == 128) begin
                    in_run   = 1'b0;
                    done_due = 1'b1;
                end
            end
            if (bus.i_ibytes_valid && bus.o_ibytes_ready) acc_words++;
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_coeffs"}, 64'(bus.o_coeffs), 64'd0);
        chk({tag, "_cvalid"}, 64'(bus.o_coeffs_valid), 64'd0);
        chk({tag, "_iready"}, 64'(bus.o_ibytes_ready), 64'd0);
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.o_done), 64'd0);
    endtask

    task automatic do_reset();
        bus.i_start        = 1'b0;
        bus.i_ibytes_valid = 1'b0;
        bus.i_coeffs_ready = 1'b1;
        rstn = 1'b0;
        @(posedge clk); #1;
        in_run     = 1'b0;
        done_due   = 1'b0;
        prev_stall = 1'b0;
        acc_words  = 0;
        hs_pairs   = 0;
        q.delete();
        rstn = 1'b1;
    endtask

    task automatic start_frame(input logic [3:0] l, input int nw);
        cur_l      = l;
        nwords     = nw;
        acc_words  = 0;
        hs_pairs   = 0;
        first_seen = 1'b0;
        @(posedge clk); #1;
        bus.i_l     = l;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start        = 1'b0;
        in_run             = 1'b1;
        bus.i_ibytes       = words[0];
        bus.i_ibytes_valid = 1'b1;
        bus.i_coeffs_ready = 1'b1;
    endtask

    task automatic drive_cycle(input bit rdy, input bit restart);
        @(posedge clk); #1;
        bus.i_ibytes       = words[acc_words % 48];
        bus.i_ibytes_valid = (acc_words < nwords);
        bus.i_coeffs_ready = rdy;
        bus.i_start        = restart;
        if (restart) bus.i_l = 4'd4;
    endtask

    task automatic run_frame(input logic [3:0] l, input int nw, input int stall_at,
                             input int stall_len, input int restart_at, input bit rand_rdy);
        int cyc;
        int d0;
        bit rdy;
        d0 = done_cnt;
        start_frame(l, nw);
        cyc = 0;
        while ((done_cnt == d0) && (cyc < 3000)) begin
            rdy = !((cyc >= stall_at) && (cyc < stall_at + stall_len));
            if (rand_rdy) rdy = rdy && ($urandom_range(0, 3) != 0);
            drive_cycle(rdy, cyc == restart_at);
            if ((stall_len > 0) && (cyc == stall_at + stall_len - 1))
                chk("stall_ready_low", 64'(bus.o_ibytes_ready), 64'd0);
            cyc++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got no done expected done within 3000 cycles (l=%0d)", l);
        end
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0);
        chk("word_count", 64'(acc_words), 64'(nw));
        chk("pair_count", 64'(hs_pairs), 64'd128);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    start_vec_t tbl[16];

    initial begin
        int cyc;

        for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), 1'b0, 1'b0};
        tbl[1]  = '{4'd1,  1'b1, 1'b1};
        tbl[4]  = '{4'd4,  1'b1, 1'b1};
        tbl[5]  = '{4'd5,  1'b1, 1'b1};
        tbl[10] = '{4'd10, 1'b1, 1'b1};
        tbl[11] = '{4'd11, 1'b1, 1'b1};
        tbl[12] = '{4'd12, 1'b1, 1'b1};

        rstn               = 1'b0;
        bus.i_start        = 1'b0;
        bus.i_l            = 4'd0;
        bus.i_ibytes       = '0;
        bus.i_ibytes_valid = 1'b0;
        bus.i_coeffs_ready = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();
        check_idle_zero("reset");
        mon_en = 1'b1;

        // Start acceptance for every i_l value
        for (int i = 0; i < 16; i++) begin
            cur_l     = tbl[i].l;
            acc_words = 0;
            hs_pairs  = 0;
            @(posedge clk); #1;
            bus.i_l     = tbl[i].l;
            bus.i_start = 1'b1;
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            in_run      = tbl[i].exp_busy;
            chk("start_busy", 64'(bus.o_busy), 64'(tbl[i].exp_busy));
            chk("start_iready", 64'(bus.o_ibytes_ready), 64'(tbl[i].exp_rdy));
            do_reset();
        end

        // L=1, alternating bits: every pair is {1, 0}
        for (int i = 0; i < 256; i++) coefs[i] = 12'(i % 2);
        pack(4'd1);
        for (int i = 0; i < 128; i++) q.push_back(24'h001000);
        run_frame(4'd1, 4, -1, 0, -1, 1'b0);

        // L=12 with reduction boundary values in the first pair
        rand_coefs(4'd12);
        coefs[0] = 12'hFFF;
        coefs[1] = 12'hD01;
        coefs[2] = 12'd3328;
        coefs[3] = 12'd3330;
        pack(4'd12);
        push_expected(4'd12);
        run_frame(4'd12, 48, -1, 0, -1, 1'b0);
        chk("l12_first_pair", 64'(first_pair), 64'h0002FE);

        // L=10 random, with a stray start mid-frame
        rand_coefs(4'd10);
        pack(4'd10);
        push_expected(4'd10);
        run_frame(4'd10, 40, -1, 0, 30, 1'b0);

        // L=4 with a 5-cycle downstream stall
        rand_coefs(4'd4);
        pack(4'd4);
        push_expected(4'd4);
        run_frame(4'd4, 16, 20, 5, -1, 1'b0);

        // L=11 with random downstream backpressure
        rand_coefs(4'd11);
        pack(4'd11);
        push_expected(4'd11);
        run_frame(4'd11, 44, -1, 0, -1, 1'b1);

        // L=5 aborted by reset after three words, then a clean frame
        rand_coefs(4'd5);
        pack(4'd5);
        push_expected(4'd5);
        start_frame(4'd5, 20);
        cyc = 0;
        while ((acc_words < 3) && (cyc < 500)) begin
            drive_cycle(1'b1, 1'b0);
            cyc++;
        end
        chk("abort_words", 64'(acc_words), 64'd3);
        do_reset();
        check_idle_zero("abort");
        rand_coefs(4'd5);
        pack(4'd5);
        push_expected(4'd5);
        run_frame(4'd5, 20, -1, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
